hwpe_stream_fault_monitor: RTL and testbench

Collects the `fault_detected_o` mismatch flags from a bank of copy sinks that guard a duplicated HWPE stream network. It records which sinks faulted and counts faulty cycles. Once a threshold is reached it escalates to an interrupt and a stream-halt request. It sits directly downstream of the copy sinks and feeds the engine controller or interrupt logic.

---
 rtl/hwpe_stream_package.sv | 26 ++
 rtl/hwpe_stream_sat_counter.sv | 35 +++
 rtl/hwpe_stream_fault_monitor.sv | 172 +++++++++++++++++
 tb/tb_hwpe_stream_fault_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_package.sv
// -----------------------------------------------------------------------------
// hwpe_stream_package
//   Shared types and helpers for the HWPE stream fault-monitoring blocks.
//   - fault_mon_state_t : escalation FSM states (MONITOR, ALERT, RECOVER)
//   - lowest_set_idx()  : priority encoder returning the index of the lowest
//                         set bit of a vector of up to 32 bits (0 if none set)
// -----------------------------------------------------------------------------
package hwpe_stream_package;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    ALERT   = 2'd1,
    RECOVER = 2'd2
  } fault_mon_state_t;

  // Scanning from the top down lets the lowest set bit win the last write.
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hwpe_stream_sat_counter.sv
// -----------------------------------------------------------------------------
// hwpe_stream_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   : clock
//     rst   : asynchronous active-high reset (count -> 0)
//     clear : synchronous clear, wins over inc
//     inc   : add one this cycle (ignored once saturated)
//     count : registered count value, WIDTH bits
// -----------------------------------------------------------------------------
module hwpe_stream_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hwpe_stream_fault_monitor.sv
// -----------------------------------------------------------------------------
// hwpe_stream_fault_monitor
//   Collects fault_detected flags from a bank of copy sinks guarding a
//   duplicated HWPE stream network, records which sinks faulted, counts faulty
//   cycles and escalates to an interrupt plus a stream-halt request once
//   THRESHOLD faulty cycles have been seen since the last acknowledge.
//
//   Optional feature macro: HWPE_STREAM_FAULT_FIRST_IDX_EN
//     defined   -> first_fault_idx_o captures the lowest asserted sink index of
//                  the first faulty cycle after reset/clear and holds it.
//     undefined -> first_fault_idx_o is tied to 0, no capture register.
//
//   Ports:
//     clk_i             : clock
//     rst_i             : asynchronous active-high reset
//     clear_i           : synchronous clear, same effect as reset, top priority
//     enable_i          : when low, fault_i is ignored
//     fault_i           : per-sink mismatch flags (NB_SINKS, NB_SINKS <= 32)
//     fault_ack_i       : acknowledge, only honoured in ALERT
//     fault_sticky_o    : per-sink sticky fault flags
//     fault_count_o     : cumulative faulty cycles, saturating
//     first_fault_idx_o : index of the first faulting sink
//     fault_irq_o       : level interrupt, high in ALERT
//     halt_o            : stream freeze request, high in ALERT and RECOVER
//   All outputs are registered.
// -----------------------------------------------------------------------------
module hwpe_stream_fault_monitor
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_SINKS       = 4,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned THRESHOLD      = 1,
  parameter int unsigned RECOVER_CYCLES = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       clear_i,
  input  logic                                       enable_i,
  input  logic [NB_SINKS-1:0]                        fault_i,
  input  logic                                       fault_ack_i,
  output logic [NB_SINKS-1:0]                        fault_sticky_o,
  output logic [CNT_WIDTH-1:0]                       fault_count_o,
  output logic [((NB_SINKS > 1) ? $clog2(NB_SINKS) : 1)-1:0] first_fault_idx_o,
  output logic                                       fault_irq_o,
  output logic                                       halt_o
);

  localparam int unsigned IDX_W = (NB_SINKS > 1) ? $clog2(NB_SINKS) : 1;
  localparam int unsigned REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_WIDTH:0] THR      = (CNT_WIDTH+1)'(THRESHOLD);
  localparam logic [REC_W-1:0]   REC_LOAD = REC_W'(RECOVER_CYCLES - 1);

  fault_mon_state_t      state_q, state_d;
  logic [REC_W-1:0]      rec_cnt_q, rec_cnt_d;
  logic [CNT_WIDTH-1:0]  esc_cnt;
  logic [NB_SINKS-1:0]   sticky_q;
  logic                  irq_q, halt_q;
  logic                  faulty, escalate, esc_inc, esc_clear;

  // A faulty cycle counts once no matter how many sinks flag it.
  assign faulty = enable_i & (|fault_i);

  // Compare one bit wider so esc_cnt + 1 cannot wrap.
  assign escalate  = (state_q == MONITOR) & faulty & (({1'b0, esc_cnt} + 1'b1) >= THR);
  assign esc_inc   = (state_q == MONITOR) & faulty & ~escalate;
  assign esc_clear = clear_i | ((state_q == ALERT) & fault_ack_i);

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      MONITOR: begin
        if (escalate) state_d = ALERT;
      end
      ALERT: begin
        if (fault_ack_i) begin
          state_d   = RECOVER;
          rec_cnt_d = REC_LOAD;
        end
      end
      RECOVER: begin
        if (rec_cnt_q == '0) state_d = MONITOR;
        else                 rec_cnt_d = rec_cnt_q - 1'b1;
      end
      default: state_d = MONITOR;
    endcase
    if (clear_i) begin
      state_d   = MONITOR;
      rec_cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so irq/halt rise on the edge
  // that enters ALERT and halt falls on the edge that re-enters MONITOR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= MONITOR;
      rec_cnt_q <= '0;
      irq_q     <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      irq_q     <= (state_d == ALERT);
      halt_q    <= (state_d != MONITOR);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else if (clear_i) begin
      sticky_q <= '0;
    end else if (enable_i) begin
      sticky_q <= sticky_q | fault_i;
    end
  end

  hwpe_stream_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) i_fault_count (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (clear_i),
    .inc   (faulty),
    .count (fault_count_o)
  );

  hwpe_stream_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) i_esc_count (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (esc_clear),
    .inc   (esc_inc),
    .count (esc_cnt)
  );

`ifdef HWPE_STREAM_FAULT_FIRST_IDX_EN
  logic [31:0]      fault_ext;
  logic [IDX_W-1:0] idx_q;
  logic             idx_vld_q;

  always_comb begin
    fault_ext               = '0;
    fault_ext[NB_SINKS-1:0] = fault_i;
  end

  // Only the first faulty cycle after reset/clear is captured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
    end else if (clear_i) begin
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
    end else if (faulty && !idx_vld_q) begin
      idx_q     <= IDX_W'(lowest_set_idx(fault_ext));
      idx_vld_q <= 1'b1;
    end
  end

  assign first_fault_idx_o = idx_q;
`else
  assign first_fault_idx_o = '0;
`endif

  assign fault_sticky_o = sticky_q;
  assign fault_irq_o    = irq_q;
  assign halt_o         = halt_q;

endmodule

// File: tb/tb_hwpe_stream_fault_monitor.sv
// -----------------------------------------------------------------------------
// tb_hwpe_stream_fault_monitor
//   Drives two monitor instances with identical stimulus:
//     dut_a : NB_SINKS=4, CNT_WIDTH=4, THRESHOLD=3, RECOVER_CYCLES=4
//     dut_b : NB_SINKS=4, CNT_WIDTH=8, THRESHOLD=1, RECOVER_CYCLES=2
//   Inputs change on the falling edge; a behavioural model pushes the expected
//   post-edge outputs into per-instance queues, and a monitor pops and compares
//   them 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_fault_monitor;

  logic       clk = 1'b0;
  logic       rst_i, clear_i, enable_i, fault_ack_i;
  logic [3:0] fault_i;

  logic [3:0] sticky_a, sticky_b;
  logic [3:0] count_a;
  logic [7:0] count_b;
  logic [1:0] idx_a, idx_b;
  logic       irq_a, irq_b, halt_a, halt_b;

  always #5 clk = ~clk;

  hwpe_stream_fault_monitor #(
    .NB_SINKS(4), .CNT_WIDTH(4), .THRESHOLD(3), .RECOVER_CYCLES(4)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
    .fault_i(fault_i), .fault_ack_i(fault_ack_i),
    .fault_sticky_o(sticky_a), .fault_count_o(count_a),
    .first_fault_idx_o(idx_a), .fault_irq_o(irq_a), .halt_o(halt_a)
  );

  hwpe_stream_fault_monitor #(
    .NB_SINKS(4), .CNT_WIDTH(8), .THRESHOLD(1), .RECOVER_CYCLES(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
    .fault_i(fault_i), .fault_ack_i(fault_ack_i),
    .fault_sticky_o(sticky_b), .fault_count_o(count_b),
    .first_fault_idx_o(idx_b), .fault_irq_o(irq_b), .halt_o(halt_b)
  );

  typedef struct packed {
    logic [31:0] sticky;
    logic [31:0] count;
    logic [31:0] idx;
    logic [31:0] irq;
    logic [31:0] halt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  localparam int MD_MON = 0, MD_ALERT = 1, MD_REC = 2;
  int thr  [2] = '{3, 1};
  int cmax [2] = '{15, 255};
  int rlen [2] = '{4, 2};

  int m_mode[2], m_sticky[2], m_count[2], m_esc[2], m_rec[2], m_idx[2];
  bit m_cap[2];

  task automatic model_reset(input int i);
    m_mode[i] = MD_MON; m_sticky[i] = 0; m_count[i] = 0;
    m_esc[i] = 0; m_rec[i] = 0; m_idx[i] = 0; m_cap[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input logic e, input logic [3:0] f,
                            input logic a, input logic c);
    bit fy;
    if (c) begin
      model_reset(i);
      return;
    end
    fy = e && (f != 4'b0);
    if (e) m_sticky[i] = m_sticky[i] | int'(f);
    if (fy && m_count[i] < cmax[i]) m_count[i]++;
`ifdef HWPE_STREAM_FAULT_FIRST_IDX_EN
    if (fy && !m_cap[i]) begin
      m_cap[i] = 1'b1;
      for (int k = 3; k >= 0; k--) if (f[k]) m_idx[i] = k;
    end
`endif
    case (m_mode[i])
      MD_MON: if (fy) begin
        if (m_esc[i] + 1 >= thr[i]) m_mode[i] = MD_ALERT;
        else                        m_esc[i]++;
      end
      MD_ALERT: if (a) begin
        m_mode[i] = MD_REC;
        m_rec[i]  = rlen[i];
        m_esc[i]  = 0;
      end
      default: begin
        m_rec[i]--;
        if (m_rec[i] == 0) m_mode[i] = MD_MON;
      end
    endcase
  endtask

  function automatic exp_t model_out(input int i);
    exp_t o;
    o.sticky = m_sticky[i];
    o.count  = m_count[i];
    o.idx    = m_idx[i];
    o.irq    = (m_mode[i] == MD_ALERT) ? 1 : 0;
    o.halt   = (m_mode[i] != MD_MON) ? 1 : 0;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  bit prev_rst = 1'b1;

  task automatic step(input logic r, input logic c, input logic e,
                      input logic [3:0] f, input logic a);
    @(negedge clk);
    rst_i = r; clear_i = c; enable_i = e; fault_i = f; fault_ack_i = a;
    if (r && !prev_rst) begin
      #1;
      check("async_rst.a.sticky", 32'(sticky_a), 0);
      check("async_rst.a.count",  32'(count_a),  0);
      check("async_rst.a.irq",    32'(irq_a),    0);
      check("async_rst.a.halt",   32'(halt_a),   0);
      check("async_rst.a.idx",    32'(idx_a),    0);
      check("async_rst.b.sticky", 32'(sticky_b), 0);
      check("async_rst.b.count",  32'(count_b),  0);
      check("async_rst.b.irq",    32'(irq_b),    0);
      check("async_rst.b.halt",   32'(halt_b),   0);
      check("async_rst.b.idx",    32'(idx_b),    0);
    end
    prev_rst = r;
    for (int i = 0; i < 2; i++) begin
      if (r) model_reset(i);
      else   model_step(i, e, f, a, c);
    end
    q_a.push_back(model_out(0));
    q_b.push_back(model_out(1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
  endtask

  task automatic flt(input logic [3:0] f);
    step(1'b0, 1'b0, 1'b1, f, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin : mon
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0 && q_b.size() > 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("a.sticky", 32'(sticky_a), ea.sticky);
        check("a.count",  32'(count_a),  ea.count);
        check("a.idx",    32'(idx_a),    ea.idx);
        check("a.irq",    32'(irq_a),    ea.irq);
        check("a.halt",   32'(halt_a),   ea.halt);
        check("b.sticky", 32'(sticky_b), eb.sticky);
        check("b.count",  32'(count_b),  eb.count);
        check("b.idx",    32'(idx_b),    eb.idx);
        check("b.irq",    32'(irq_b),    eb.irq);
        check("b.halt",   32'(halt_b),   eb.halt);
      end
    end
  end

  initial begin
    logic r, c, e, a;
    logic [3:0] f;
    rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b0; fault_i = '0; fault_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) model_reset(i);

    // reset state
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    idle(1);

    // single fault escalates dut_b (threshold 1)
    flt(4'b0100);
    idle(1);

    // clear beats a concurrent fault
    step(1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);

    // threshold 3 on dut_a: two spaced faults, then the third escalates
    flt(4'b0010); idle(1);
    flt(4'b1000); idle(1);
    flt(4'b0001); idle(1);

    // fault and ack together in ALERT, then watch halt drop
    step(1'b0, 1'b0, 1'b1, 4'b0010, 1'b1);
    idle(6);

    // disabled faults are ignored, then the same pattern enabled
    clr();
    step(1'b0, 1'b0, 1'b0, 4'b1010, 1'b0);
    flt(4'b1010);
    idle(1);

    // saturation of the 4-bit count
    clr();
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, 1'b1, 4'(1 << (k % 4)), 1'(k % 2));
    idle(2);

    // asynchronous reset in the middle of RECOVER
    clr();
    flt(4'b0001); flt(4'b0010); flt(4'b0100);
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
    idle(1);

    // clear while in ALERT
    flt(4'b1000); flt(4'b0100); flt(4'b0010);
    idle(1);
    clr();
    idle(2);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      r = ($urandom_range(0, 99) < 1);
      c = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 85);
      f = ($urandom_range(0, 99) < 35) ? 4'($urandom) : 4'b0000;
      a = ($urandom_range(0, 99) < 25);
      step(r, c, e, f, a);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q_a.size() + q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
